axi_slave_mem: RTL

//  AXI4 slave memory model: the responder on the far side of the VIP master bus.

---
 rtl/axi_slave_mem_pkg.sv | 28 ++
 rtl/axi_slave_mem_if.sv | 55 +++++
 rtl/axi_slave_mem_addr_gen.sv | 40 ++++
 rtl/axi_slave_mem.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_mem_pkg.sv
// Shared types for the AXI4 slave memory model: burst/response encodings and FSM states.
// Pure type and helper definitions; no logic, no latency.
// No flow control of its own; users own all handshaking.
package axi_slave_mem_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  // DECERR outranks SLVERR, which outranks OKAY.
  function automatic resp_e pick_resp(input logic dec, input logic slv);
    return dec ? DECERR : (slv ? SLVERR : OKAY);
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) between a master and the slave memory model.
// Wires only; no latency.
// Standard valid/ready on every channel; master and slave modports set the directions.
interface axi_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [LEN_WIDTH-1:0]    AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [LEN_WIDTH-1:0]    ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );
endinterface

// File: rtl/axi_slave_mem_addr_gen.sv
// Next-beat address for FIXED / INCR / WRAP bursts; AxSIZE above the bus width is clamped.
// Purely combinational, zero latency.
// No flow control; the owning FSM decides when to take the result.
module axi_burst_addr_gen
  import axi_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [LEN_WIDTH-1:0]  len,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  logic [2:0]            size_c;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_lo;

  // Legal AXI wrap lengths are 2/4/8/16 beats, so the wrap window is a power of two and the
  // floor-to-boundary reduces to masking.
  always_comb begin
    next_addr = '0;
    size_c    = (size > MAX_SIZE) ? MAX_SIZE : size;
    step      = ADDR_WIDTH'(1) << size_c;
    total     = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size_c;
    incr      = addr + step;
    wrap_lo   = addr & ~(total - ADDR_WIDTH'(1));
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = wrap_lo | (incr & (total - ADDR_WIDTH'(1)));
      default: next_addr = incr;   // INCR, and reserved treated as INCR
    endcase
  end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write (AW->W->B) and read (AR->R) FSMs over a byte-strobed word array.
// Latency: first WREADY 1 cycle after AW, BVALID 1 cycle after last W; first RVALID 1 cycle after AR.
// Backpressure: B and R outputs held stable until BREADY/RREADY. Define AXI_SLV_DECERR_EN for DECERR on out-of-range words.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input logic            ACLK,
  input logic            ARESETn,
  axi_slave_mem_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Not reset: contents survive ARESETn.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a >> OFFS) % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  wstate_e               w_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0]  w_len, w_beat;
  logic [2:0]            w_size;
  burst_e                w_burst;
  logic                  w_slverr, w_decerr, w_oob;

  rstate_e               r_state, r_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_len, r_beat;
  logic [2:0]            r_size;
  burst_e                r_burst;
  logic                  r_slverr, r_oob, r_held;
  logic [DATA_WIDTH-1:0] r_hold_dat;

  logic aw_hs, w_hs, ar_hs, r_hs;
  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;
  assign r_hs  = bus.RVALID && bus.RREADY;

`ifdef AXI_SLV_DECERR_EN
  assign w_oob = (w_addr >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
  assign r_oob = (r_addr >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH))
    u_w_addr_gen (.addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nxt));

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH))
    u_r_addr_gen (.addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nxt));

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // Write FSM next state and AW/W/B outputs; ready gated by reset so every output is 0 in reset.
  always_comb begin
    w_state_nxt = w_state;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BID     = '0;
    bus.BRESP   = OKAY;
    case (w_state)
      W_IDLE: begin
        bus.AWREADY = ARESETn;
        if (bus.AWVALID && ARESETn) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        bus.WREADY = 1'b1;
        if (bus.WVALID && (w_beat == w_len)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bus.BVALID = 1'b1;
        bus.BID    = w_id;
        bus.BRESP  = pick_resp(w_decerr, w_slverr);
        if (bus.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst context: latch on AW, advance and accumulate errors per W beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_beat <= '0; w_size <= '0;
      w_burst <= INCR; w_slverr <= 1'b0; w_decerr <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id     <= bus.AWID;
        w_addr   <= bus.AWADDR;
        w_len    <= bus.AWLEN;
        w_size   <= bus.AWSIZE;
        w_burst  <= burst_e'(bus.AWBURST);
        w_beat   <= '0;
        w_slverr <= (burst_e'(bus.AWBURST) == RSVD);
        w_decerr <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr_nxt;
        w_beat <= w_beat + 1'b1;
        if (bus.WLAST != (w_beat == w_len)) w_slverr <= 1'b1;
        if (w_oob) w_decerr <= 1'b1;
      end
    end
  end

  // Byte-strobed memory write; out-of-range beats are dropped when decode errors are enabled.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // Read FSM next state and AR/R outputs; RDATA switches to the captured copy once a beat stalls.
  always_comb begin
    r_state_nxt = r_state;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    bus.RRESP   = OKAY;
    bus.RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        bus.ARREADY = ARESETn;
        if (bus.ARVALID && ARESETn) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        bus.RVALID = 1'b1;
        bus.RID    = r_id;
        bus.RDATA  = r_held ? r_hold_dat : (r_oob ? '0 : mem[word_idx(r_addr)]);
        bus.RRESP  = pick_resp(r_oob, r_slverr);
        bus.RLAST  = (r_beat == r_len);
        if (bus.RREADY && (r_beat == r_len)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst context, plus a data snapshot so a stalled beat stays stable under concurrent writes.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_beat <= '0; r_size <= '0;
      r_burst <= INCR; r_slverr <= 1'b0; r_held <= 1'b0; r_hold_dat <= '0;
    end else begin
      if (ar_hs) begin
        r_id     <= bus.ARID;
        r_addr   <= bus.ARADDR;
        r_len    <= bus.ARLEN;
        r_size   <= bus.ARSIZE;
        r_burst  <= burst_e'(bus.ARBURST);
        r_beat   <= '0;
        r_slverr <= (burst_e'(bus.ARBURST) == RSVD);
      end
      if (r_hs) begin
        r_addr <= r_addr_nxt;
        r_beat <= r_beat + 1'b1;
        r_held <= 1'b0;
      end else if (bus.RVALID && !r_held) begin
        r_held     <= 1'b1;
        r_hold_dat <= bus.RDATA;
      end
    end
  end
endmodule
